fifo_stream_adapter: RTL and testbench

FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

---
 rtl/fifo_stream_adapter.sv | 122 ++++++++++++
 tb/tb_fifo_stream_adapter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: pulls words from a show-ahead-less upstream FIFO
// (data valid one cycle after the read strobe) into a 3-entry in-order
// buffer and presents them as a valid/ready stream with burst framing.
// Optional statistics outputs are enabled with FIFO_STREAM_ADAPTER_STATS_EN.
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 12,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
  ,
  output logic [31:0]           word_cnt_o,
  output logic [15:0]           stall_cnt_o
`endif
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  pend_q, pend_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0] buf_q [3];
  logic [DATA_WIDTH-1:0] buf_d [3];
  logic                  xfer;

  // A read is only issued when the buffer can absorb it even if nothing drains,
  // which keeps m_ready_i out of the read path entirely.
  assign fifo_rd_en_o = rst_n_i && !fifo_empty_i &&
                        (({1'b0, occ_q} + {2'b00, pend_q}) < 3'd3);

  assign m_valid_o = (occ_q != 2'd0);
  assign m_data_o  = buf_q[0];
  assign m_last_o  = m_valid_o && (beat_cnt_q == LAST_BEAT);
  assign xfer      = m_valid_o && m_ready_i;

  // Next-state: shift out the head on a transfer, then append the arriving word behind the survivors.
  always_comb begin
    buf_d      = buf_q;
    occ_d      = occ_q;
    beat_cnt_d = beat_cnt_q;
    pend_d     = fifo_rd_en_o;
    if (xfer) begin
      buf_d[0] = buf_q[1];
      buf_d[1] = buf_q[2];
      buf_d[2] = '0;
      occ_d    = occ_q - 2'd1;
      if (beat_cnt_q == LAST_BEAT) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
    if (pend_q) begin
      case (occ_d)
        2'd0:    buf_d[0] = fifo_rdata_i;
        2'd1:    buf_d[1] = fifo_rdata_i;
        default: buf_d[2] = fifo_rdata_i;
      endcase
      occ_d = occ_d + 2'd1;
    end
  end

  // State registers; reset drops buffered and in-flight words and restarts the burst.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      occ_q      <= 2'd0;
      pend_q     <= 1'b0;
      beat_cnt_q <= '0;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      occ_q      <= occ_d;
      pend_q     <= pend_d;
      beat_cnt_q <= beat_cnt_d;
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

`ifdef FIFO_STREAM_ADAPTER_STATS_EN
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Transfer count wraps naturally; stall count saturates so long stalls stay visible.
  always_comb begin
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (xfer) begin
      word_cnt_d = word_cnt_q + 32'd1;
    end
    if (m_valid_o && !m_ready_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Statistics registers, cleared together with the datapath.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      word_cnt_q  <= 32'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign word_cnt_o  = word_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb_fifo_stream_adapter: drives fifo_stream_adapter from a queue-based
// upstream FIFO model and checks the output stream against the sequence of
// words read, with burst framing derived from the transfer count.
module tb_fifo_stream_adapter;

  localparam int DW = 12;
  localparam int BL = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          fifo_empty_i;
  logic          fifo_rd_en_o;
  logic [DW-1:0] fifo_rdata_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic          m_last_o;
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
  logic [31:0]   word_cnt_o;
  logic [15:0]   stall_cnt_o;
`endif

  fifo_stream_adapter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .fifo_rdata_i (fifo_rdata_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o)
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    ,
    .word_cnt_o   (word_cnt_o),
    .stall_cnt_o  (stall_cnt_o)
`endif
  );

  // Free-running 10 ns clock; the DUT works on the rising edge.
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;

  // fifo_q is the upstream FIFO content; exp_q holds every word already read
  // out of it but not yet delivered downstream, in order.
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  int            beat;
  bit            pend_model;
  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            cyc;
  int            rd_cnt, xfer_cnt, valid_cnt, last_cnt;
  int            first_valid_cyc, first_xfer_cyc, last_xfer_cyc;

  // One comparison: count it and report any difference.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Per-test observation counters start from zero.
  task automatic clearCounters();
    rd_cnt          = 0;
    xfer_cnt        = 0;
    valid_cnt       = 0;
    last_cnt        = 0;
    first_valid_cyc = -1;
    first_xfer_cyc  = -1;
    last_xfer_cyc   = -1;
  endtask

  // Load a word into the upstream FIFO; called between negedge and sampling.
  task automatic pushWord(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty_i = 1'b0;
  endtask

  // Sample the DUT mid-cycle, check it against the model, then advance one clock
  // and let the upstream FIFO answer any read with data in the following cycle.
  task automatic stepCycle();
    logic          rd, v, lst;
    logic [DW-1:0] d, w;
    int            buffered;
    #1;
    rd = fifo_rd_en_o;
    v  = m_valid_o;
    d  = m_data_o;
    lst = m_last_o;
    w  = '0;
    buffered = exp_q.size() - (pend_model ? 1 : 0);
    checkOutput("no_underflow", {31'd0, rd && fifo_empty_i}, 32'd0);
    checkOutput("valid_model", {31'd0, v}, {31'd0, buffered > 0});
    checkOutput("occ_bound", {31'd0, exp_q.size() <= 3}, 32'd1);
    checkOutput("last_gated", {31'd0, lst && !v}, 32'd0);
    if (prev_stall) begin
      checkOutput("hold_valid", {31'd0, v}, 32'd1);
      checkOutput("hold_data", {20'd0, d}, {20'd0, prev_data});
      checkOutput("hold_last", {31'd0, lst}, {31'd0, prev_last});
    end
    if (v) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (v && m_ready_i) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_word", 32'd1, 32'd0);
      end else begin
        checkOutput("data", {20'd0, d}, {20'd0, exp_q.pop_front()});
      end
      checkOutput("last", {31'd0, lst}, {31'd0, beat == BL - 1});
      beat = (beat + 1) % BL;
      if (lst) last_cnt++;
      if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      xfer_cnt++;
    end
    if (rd) begin
      rd_cnt++;
      if (fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        exp_q.push_back(w);
      end
    end
    pend_model = rd;
    prev_stall = v && !m_ready_i;
    prev_data  = d;
    prev_last  = lst;
    cyc++;
    @(posedge clk_i);
    #1;
    if (rd) fifo_rdata_i = w;
    fifo_empty_i = (fifo_q.size() == 0);
    @(negedge clk_i);
  endtask

  // One-cycle reset: read strobe must be blocked, outputs cleared after the edge,
  // and everything buffered or in flight is forgotten by the model.
  task automatic doReset();
    rst_n_i = 1'b0;
    #1;
    checkOutput("rst_rd_en", {31'd0, fifo_rd_en_o}, 32'd0);
    @(posedge clk_i);
    #1;
    checkOutput("rst_valid", {31'd0, m_valid_o}, 32'd0);
    checkOutput("rst_data", {20'd0, m_data_o}, 32'd0);
    checkOutput("rst_last", {31'd0, m_last_o}, 32'd0);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    checkOutput("rst_word_cnt", word_cnt_o, 32'd0);
    checkOutput("rst_stall_cnt", {16'd0, stall_cnt_o}, 32'd0);
`endif
    exp_q.delete();
    pend_model = 1'b0;
    prev_stall = 1'b0;
    beat       = 0;
    @(negedge clk_i);
    rst_n_i      = 1'b1;
    fifo_empty_i = (fifo_q.size() == 0);
  endtask

  // Run until the upstream FIFO and the adapter are both empty, with a cycle budget.
  task automatic drain(input int budget);
    int n = 0;
    while ((fifo_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_done", {31'd0, (fifo_q.size() + exp_q.size()) == 0}, 32'd1);
  endtask

  // Random traffic: 64 words arriving at random times, downstream ready at 50%.
  task automatic applyStimulus();
    int pushed = 0;
    int n = 0;
    while ((pushed < 64 || fifo_q.size() > 0 || exp_q.size() > 0) && n < 3000) begin
      if (pushed < 64 && $urandom_range(0, 2) == 0) begin
        pushWord(DW'($urandom));
        pushed++;
      end
      m_ready_i = ($urandom_range(0, 1) == 1);
      stepCycle();
      n++;
    end
    m_ready_i = 1'b1;
    checkOutput("rand_pushed", pushed, 32'd64);
    checkOutput("rand_drained", {31'd0, (fifo_q.size() + exp_q.size()) == 0}, 32'd1);
  endtask

  // Directed scenarios followed by the randomized run.
  initial begin
    int n;
    int start_cyc;
    rst_n_i      = 1'b0;
    fifo_empty_i = 1'b1;
    fifo_rdata_i = '0;
    m_ready_i    = 1'b0;
    cyc          = 0;
    beat         = 0;
    pend_model   = 1'b0;
    prev_stall   = 1'b0;
    prev_data    = '0;
    prev_last    = 1'b0;
    clearCounters();
    @(negedge clk_i);
    doReset();

    $display("[TB] single word latency");
    clearCounters();
    m_ready_i = 1'b1;
    stepCycle();
    pushWord(12'h0A5);
    start_cyc = cyc;
    for (int i = 0; i < 6; i++) stepCycle();
    checkOutput("single_latency", first_valid_cyc - start_cyc, 32'd2);
    checkOutput("single_reads", rd_cnt, 32'd1);
    checkOutput("single_xfers", xfer_cnt, 32'd1);
    // The burst continues at beat 1, so three more words end on a last beat.
    clearCounters();
    for (int i = 0; i < 3; i++) pushWord(DW'(12'h100 + i));
    drain(50);
    checkOutput("cont_lasts", last_cnt, 32'd1);

    $display("[TB] 16 word streaming burst");
    doReset();
    clearCounters();
    for (int i = 0; i < 16; i++) pushWord(DW'(12'h300 + i * 7));
    drain(100);
    checkOutput("stream_xfers", xfer_cnt, 32'd16);
    checkOutput("stream_no_bubbles", last_xfer_cyc - first_xfer_cyc, 32'd15);
    checkOutput("stream_lasts", last_cnt, 32'd4);

    $display("[TB] downstream stall");
    doReset();
    clearCounters();
    m_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) pushWord(DW'(12'hA00 + i));
    n = 0;
    while (!m_valid_o && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("stall_valid_seen", {31'd0, m_valid_o}, 32'd1);
    for (int i = 0; i < 10; i++) stepCycle();
    checkOutput("stall_reads", rd_cnt, 32'd3);
    checkOutput("stall_buffered", exp_q.size(), 32'd3);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    checkOutput("stall_cnt", {16'd0, stall_cnt_o}, 32'd10);
`endif
    m_ready_i = 1'b1;
    drain(100);
    checkOutput("stall_xfers", xfer_cnt, 32'd8);
`ifdef FIFO_STREAM_ADAPTER_STATS_EN
    checkOutput("word_cnt", word_cnt_o, 32'd8);
`endif

    $display("[TB] empty upstream");
    doReset();
    clearCounters();
    for (int i = 0; i < 20; i++) begin
      m_ready_i = i[0];
      stepCycle();
    end
    checkOutput("empty_reads", rd_cnt, 32'd0);
    checkOutput("empty_valids", valid_cnt, 32'd0);

    $display("[TB] reset mid-burst");
    doReset();
    clearCounters();
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) pushWord(DW'(12'h500 + i));
    n = 0;
    while (xfer_cnt < 2 && n < 20) begin
      stepCycle();
      n++;
    end
    checkOutput("mid_two_beats", xfer_cnt, 32'd2);
    m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    checkOutput("mid_buffered", exp_q.size(), 32'd2);
    doReset();
    clearCounters();
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) pushWord(DW'(12'h600 + i));
    drain(50);
    checkOutput("mid_new_xfers", xfer_cnt, 32'd4);
    checkOutput("mid_new_lasts", last_cnt, 32'd1);

    $display("[TB] random traffic");
    doReset();
    clearCounters();
    applyStimulus();
    checkOutput("rand_xfers", xfer_cnt, 32'd64);
    checkOutput("rand_lasts", last_cnt, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
